// File: rtl/exwb_regfile.sv
// -----------------------------------------------------------------------------
// exwb_regfile
// Execute/write-back stage for KGP-miniRISC. Captures each ALU result and its
// {carry, zero, sign} flags into a one-entry EX/WB register, commits it one
// cycle later into the register file and flag register, and serves the two
// ALU operand read ports with forwarding from the pending entry.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   rs_addr / rs_data     : read port A (combinational, forwarded)
//   rt_addr / rt_data     : read port B (combinational, forwarded)
//   ex_valid / ex_ready   : ALU result handshake (ex_ready combinational)
//   ex_dest, ex_wen,
//   ex_fen, ex_result,
//   ex_flags              : ALU result payload; flags [2] carry [1] zero [0] sign
//   wb_stall              : hold the EX/WB entry, suppress commit
//   flags_q               : committed flag register
//   wb_valid, wb_dest,
//   wb_data               : EX/WB entry state (trace/debug)
// -----------------------------------------------------------------------------
module exwb_regfile #(
    parameter int unsigned NREG = 32,
    parameter int unsigned W    = 32
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic [4:0]    rs_addr,
    input  logic [4:0]    rt_addr,
    output logic [W-1:0]  rs_data,
    output logic [W-1:0]  rt_data,

    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [4:0]    ex_dest,
    input  logic          ex_wen,
    input  logic          ex_fen,
    input  logic [W-1:0]  ex_result,
    input  logic [2:0]    ex_flags,

    input  logic          wb_stall,

    output logic [2:0]    flags_q,
    output logic          wb_valid,
    output logic [4:0]    wb_dest,
    output logic [W-1:0]  wb_data
);

    localparam int unsigned AW = 5;
    localparam int unsigned FW = 3;

    // EX/WB entry
    logic           r_wb_valid;
    logic           r_wb_wen;
    logic           r_wb_fen;
    logic [AW-1:0]  r_wb_dest;
    logic [W-1:0]   r_wb_data;
    logic [FW-1:0]  r_wb_flags;

    // Architectural state
    logic [W-1:0]   r_regs [NREG];
    logic [FW-1:0]  r_flags;

    logic           w_ready;
    logic           w_capture;
    logic           w_commit;
    logic           w_fwd_ok;

    // Handshake: an occupied entry blocks new results only while it is stalled.
    assign w_ready   = !r_wb_valid || !wb_stall;
    assign w_capture = ex_valid && w_ready;
    assign w_commit  = r_wb_valid && !wb_stall;
    assign w_fwd_ok  = r_wb_valid && r_wb_wen;

    // EX/WB pipeline register; commit and capture on the same edge simply
    // overwrite the entry, which gives one result per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_wen   <= 1'b0;
            r_wb_fen   <= 1'b0;
            r_wb_dest  <= '0;
            r_wb_data  <= '0;
            r_wb_flags <= '0;
        end else if (w_capture) begin
            r_wb_valid <= 1'b1;
            r_wb_wen   <= ex_wen;
            r_wb_fen   <= ex_fen;
            r_wb_dest  <= ex_dest;
            r_wb_data  <= ex_result;
            r_wb_flags <= ex_flags;
        end else if (w_commit) begin
            r_wb_valid <= 1'b0;
        end
    end

    // Register file commit; register 0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit && r_wb_wen && (r_wb_dest != '0)) begin
            r_regs[r_wb_dest] <= r_wb_data;
        end
    end

    // Flag register commit; a dest-0 entry may still update flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (w_commit && r_wb_fen) begin
            r_flags <= r_wb_flags;
        end
    end

    // Read port A: zero register, then forward from the pending entry, then array.
    always_comb begin
        rs_data = '0;
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (w_fwd_ok && (r_wb_dest == rs_addr)) begin
            rs_data = r_wb_data;
        end else begin
            rs_data = r_regs[rs_addr];
        end
    end

    // Read port B: same priority as port A.
    always_comb begin
        rt_data = '0;
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (w_fwd_ok && (r_wb_dest == rt_addr)) begin
            rt_data = r_wb_data;
        end else begin
            rt_data = r_regs[rt_addr];
        end
    end

    assign ex_ready = w_ready;
    assign flags_q  = r_flags;
    assign wb_valid = r_wb_valid;
    assign wb_dest  = r_wb_dest;
    assign wb_data  = r_wb_data;

endmodule

// File: tb/tb_exwb_regfile.sv
// -----------------------------------------------------------------------------
// tb_exwb_regfile
// Scenario-task bench for exwb_regfile. Expected values are pushed to a
// scoreboard queue when stimulus is driven and popped when the outputs are
// sampled. Inputs change 1ns after the rising edge; outputs are sampled 1ns
// after that, well away from the edge.
// -----------------------------------------------------------------------------
module tb_exwb_regfile;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_dest;
    logic        ex_wen;
    logic        ex_fen;
    logic [31:0] ex_result;
    logic [2:0]  ex_flags;
    logic        wb_stall;
    logic [2:0]  flags_q;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;

    exp_t sb[$];
    exp_t e;
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model state for the random scenario
    logic [31:0] m_regs [32];
    logic [2:0]  m_flags;
    logic        m_pv;
    logic        m_pwen;
    logic        m_pfen;
    logic [4:0]  m_pdest;
    logic [31:0] m_pdata;
    logic [2:0]  m_pflags;

    exwb_regfile #(.NREG(32), .W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_dest   (ex_dest),
        .ex_wen    (ex_wen),
        .ex_fen    (ex_fen),
        .ex_result (ex_result),
        .ex_flags  (ex_flags),
        .wb_stall  (wb_stall),
        .flags_q   (flags_q),
        .wb_valid  (wb_valid),
        .wb_dest   (wb_dest),
        .wb_data   (wb_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input logic [31:0] val);
        exp_t x;
        x.name = name;
        x.val  = val;
        sb.push_back(x);
    endtask

    task automatic drive_ex(input logic v, input logic [4:0] d, input logic wen,
                            input logic fen, input logic [31:0] res, input logic [2:0] fl);
        ex_valid  = v;
        ex_dest   = d;
        ex_wen    = wen;
        ex_fen    = fen;
        ex_result = res;
        ex_flags  = fl;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_pv && m_pwen && (m_pdest == a)) return m_pdata;
        return m_regs[a];
    endfunction

    // ---------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 3'd0);
        wb_stall = 1'b0;
        rs_addr  = 5'd0;
        rt_addr  = 5'd0;
        #12;
        rst_n = 1'b1;
        step();
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a);
            rt_addr = 5'(31 - a);
            push($sformatf("reset_rs[%0d]", a), 32'd0);
            push($sformatf("reset_rt[%0d]", 31 - a), 32'd0);
            #1;
            e = sb.pop_front(); n_total++;
            if (rs_data !== e.val) $display("FAIL %s: got %h exp %h", e.name, rs_data, e.val);
            else n_pass++;
            e = sb.pop_front(); n_total++;
            if (rt_data !== e.val) $display("FAIL %s: got %h exp %h", e.name, rt_data, e.val);
            else n_pass++;
        end
        push("reset_flags", 32'd0);
        push("reset_ready", 32'd1);
        push("reset_wb_valid", 32'd0);
        push("reset_wb_data", 32'd0);
        e = sb.pop_front(); n_total++;
        if (32'(flags_q) !== e.val) $display("FAIL %s: got %h exp %h", e.name, flags_q, e.val);
        else n_pass++;
        e = sb.pop_front(); n_total++;
        if (32'(ex_ready) !== e.val) $display("FAIL %s: got %h exp %h", e.name, ex_ready, e.val);
        else n_pass++;
        e = sb.pop_front(); n_total++;
        if (32'(wb_valid) !== e.val) $display("FAIL %s: got %h exp %h", e.name, wb_valid, e.val);
        else n_pass++;
        e = sb.pop_front(); n_total++;
        if (wb_data !== e.val) $display("FAIL %s: got %h exp %h", e.name, wb_data, e.val);
        else n_pass++;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_forward_commit();
        drive_ex(1'b1, 5'd5, 1'b1, 1'b1, 32'hDEADBEEF, 3'b101);
        rs_addr = 5'd5;
        push("pre_cap_rs5", 32'd0);
        #1;
        e = sb.pop_front(); n_total++;
        if (rs_data !== e.val) $display("FAIL %s: got %h exp %h", e.name, rs_data, e.val);
        else n_pass++;
        step();
        drive_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 3'd0);
        push("fwd_rs5", 32'hDEADBEEF);
        push("fwd_flags_old", 32'd0);
        push("fwd_wb_valid", 32'd1);
        #1;
        e = sb.pop_front(); n_total++;
        if (rs_data !== e.val) $display("FAIL %s: got %h exp %h", e.name, rs_data, e.val);
        else n_pass++;
        e = sb.pop_front(); n_total++;
        if (32'(flags_q) !== e.val) $display("FAIL %s: got %h exp %h", e.name, flags_q, e.val);
        else n_pass++;
        e = sb.pop_front(); n_total++;
        if (32'(wb_valid) !== e.val) $display("FAIL %s: got %h exp %h", e.name, wb_valid, e.val);
        else n_pass++;
        step();
        push("commit_rs5", 32'hDEADBEEF);
        push("commit_flags", 32'b101);
        push("commit_wb_valid", 32'd0);
        #1;
        e = sb.pop_front(); n_total++;
        if (rs_data !== e.val) $display("FAIL %s: got %h exp %h", e.name, rs_data, e.val);
        else n_pass++;
        e = sb.pop_front(); n_total++;
        if (32'(flags_q) !== e.val) $display("FAIL %s: got %h exp %h", e.name, flags_q, e.val);
        else n_pass++;
        e = sb.pop_front(); n_total++;
        if (32'(wb_valid) !== e.val) $display("FAIL %s: got %h exp %h", e.name, wb_valid, e.val);
        else n_pass++;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_back_to_back();
        rt_addr = 5'd7;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 3) drive_ex(1'b1, 5'd7, 1'b1, 1'b0, 32'(k), 3'd0);
            else        drive_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 3'd0);
            // k=1 reads the old value; afterwards each cycle sees the previous write
            if (k == 1)      push("b2b_rt7_0", 32'd0);
            else if (k <= 4) push($sformatf("b2b_rt7_%0d", k), 32'(k - 1));
            else             push("b2b_rt7_array", 32'd3);
            #1;
            e = sb.pop_front(); n_total++;
            if (rt_data !== e.val) $display("FAIL %s: got %h exp %h", e.name, rt_data, e.val);
            else n_pass++;
            step();
        end
        push("b2b_wb_valid", 32'd0);
        e = sb.pop_front(); n_total++;
        if (32'(wb_valid) !== e.val) $display("FAIL %s: got %h exp %h", e.name, wb_valid, e.val);
        else n_pass++;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_stall();
        // stall with an empty stage is ignored
        wb_stall = 1'b1;
        drive_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 3'd0);
        push("idle_stall_ready", 32'd1);
        #1;
        e = sb.pop_front(); n_total++;
        if (32'(ex_ready) !== e.val) $display("FAIL %s: got %h exp %h", e.name, ex_ready, e.val);
        else n_pass++;
        wb_stall = 1'b0;
        drive_ex(1'b1, 5'd9, 1'b1, 1'b0, 32'h1234, 3'b111);
        step();
        // entry for reg 9 pending; producer now holds reg 10
        wb_stall = 1'b1;
        drive_ex(1'b1, 5'd10, 1'b1, 1'b1, 32'hABCD, 3'b011);
        rs_addr = 5'd9;
        rt_addr = 5'd10;
        for (int c = 0; c < 3; c++) begin
            push($sformatf("stall_ready_%0d", c), 32'd0);
            push($sformatf("stall_rs9_%0d", c), 32'h1234);
            push($sformatf("stall_rt10_%0d", c), 32'd0);
            push($sformatf("stall_wb_dest_%0d", c), 32'd9);
            push($sformatf("stall_flags_%0d", c), 32'b101);
            #1;
            e = sb.pop_front(); n_total++;
            if (32'(ex_ready) !== e.val) $display("FAIL %s: got %h exp %h", e.name, ex_ready, e.val);
            else n_pass++;
            e = sb.pop_front(); n_total++;
            if (rs_data !== e.val) $display("FAIL %s: got %h exp %h", e.name, rs_data, e.val);
            else n_pass++;
            e = sb.pop_front(); n_total++;
            if (rt_data !== e.val) $display("FAIL %s: got %h exp %h", e.name, rt_data, e.val);
            else n_pass++;
            e = sb.pop_front(); n_total++;
            if (32'(wb_dest) !== e.val) $display("FAIL %s: got %h exp %h", e.name, wb_dest, e.val);
            else n_pass++;
            e = sb.pop_front(); n_total++;
            if (32'(flags_q) !== e.val) $display("FAIL %s: got %h exp %h", e.name, flags_q, e.val);
            else n_pass++;
            step();
        end
        wb_stall = 1'b0;
        push("release_ready", 32'd1);
        #1;
        e = sb.pop_front(); n_total++;
        if (32'(ex_ready) !== e.val) $display("FAIL %s: got %h exp %h", e.name, ex_ready, e.val);
        else n_pass++;
        step();
        drive_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 3'd0);
        push("release_wb_dest", 32'd10);
        push("release_rs9_array", 32'h1234);
        push("release_rt10_fwd", 32'hABCD);
        #1;
        e = sb.pop_front(); n_total++;
        if (32'(wb_dest) !== e.val) $display("FAIL %s: got %h exp %h", e.name, wb_dest, e.val);
        else n_pass++;
        e = sb.pop_front(); n_total++;
        if (rs_data !== e.val) $display("FAIL %s: got %h exp %h", e.name, rs_data, e.val);
        else n_pass++;
        e = sb.pop_front(); n_total++;
        if (rt_data !== e.val) $display("FAIL %s: got %h exp %h", e.name, rt_data, e.val);
        else n_pass++;
        step();
        push("release_flags", 32'b011);
        push("release_rt10_array", 32'hABCD);
        #1;
        e = sb.pop_front(); n_total++;
        if (32'(flags_q) !== e.val) $display("FAIL %s: got %h exp %h", e.name, flags_q, e.val);
        else n_pass++;
        e = sb.pop_front(); n_total++;
        if (rt_data !== e.val) $display("FAIL %s: got %h exp %h", e.name, rt_data, e.val);
        else n_pass++;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reg0();
        drive_ex(1'b1, 5'd0, 1'b1, 1'b1, 32'hFFFFFFFF, 3'b010);
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        step();
        drive_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 3'd0);
        push("r0_pend_rs", 32'd0);
        push("r0_pend_rt", 32'd0);
        push("r0_pend_flags", 32'b011);
        #1;
        e = sb.pop_front(); n_total++;
        if (rs_data !== e.val) $display("FAIL %s: got %h exp %h", e.name, rs_data, e.val);
        else n_pass++;
        e = sb.pop_front(); n_total++;
        if (rt_data !== e.val) $display("FAIL %s: got %h exp %h", e.name, rt_data, e.val);
        else n_pass++;
        e = sb.pop_front(); n_total++;
        if (32'(flags_q) !== e.val) $display("FAIL %s: got %h exp %h", e.name, flags_q, e.val);
        else n_pass++;
        step();
        push("r0_commit_rs", 32'd0);
        push("r0_commit_flags", 32'b010);
        #1;
        e = sb.pop_front(); n_total++;
        if (rs_data !== e.val) $display("FAIL %s: got %h exp %h", e.name, rs_data, e.val);
        else n_pass++;
        e = sb.pop_front(); n_total++;
        if (32'(flags_q) !== e.val) $display("FAIL %s: got %h exp %h", e.name, flags_q, e.val);
        else n_pass++;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset_mid();
        drive_ex(1'b1, 5'd12, 1'b1, 1'b1, 32'h5555AAAA, 3'b111);
        step();
        drive_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 3'd0);
        rs_addr = 5'd12;
        rt_addr = 5'd5;
        push("mid_pend_valid", 32'd1);
        #1;
        e = sb.pop_front(); n_total++;
        if (32'(wb_valid) !== e.val) $display("FAIL %s: got %h exp %h", e.name, wb_valid, e.val);
        else n_pass++;
        rst_n = 1'b0;
        push("mid_rst_valid", 32'd0);
        push("mid_rst_rs12", 32'd0);
        push("mid_rst_rt5", 32'd0);
        #1;
        e = sb.pop_front(); n_total++;
        if (32'(wb_valid) !== e.val) $display("FAIL %s: got %h exp %h", e.name, wb_valid, e.val);
        else n_pass++;
        e = sb.pop_front(); n_total++;
        if (rs_data !== e.val) $display("FAIL %s: got %h exp %h", e.name, rs_data, e.val);
        else n_pass++;
        e = sb.pop_front(); n_total++;
        if (rt_data !== e.val) $display("FAIL %s: got %h exp %h", e.name, rt_data, e.val);
        else n_pass++;
        step();
        rst_n = 1'b1;
        step();
        step();
        push("mid_after_rs12", 32'd0);
        push("mid_after_flags", 32'd0);
        #1;
        e = sb.pop_front(); n_total++;
        if (rs_data !== e.val) $display("FAIL %s: got %h exp %h", e.name, rs_data, e.val);
        else n_pass++;
        e = sb.pop_front(); n_total++;
        if (32'(flags_q) !== e.val) $display("FAIL %s: got %h exp %h", e.name, flags_q, e.val);
        else n_pass++;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_random();
        logic held;
        logic rdy;
        held = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_flags = 3'd0;
        m_pv = 1'b0; m_pwen = 1'b0; m_pfen = 1'b0;
        m_pdest = 5'd0; m_pdata = 32'd0; m_pflags = 3'd0;
        for (int n = 0; n < 400; n++) begin
            if (!held) begin
                drive_ex(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                         1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                         $urandom, 3'($urandom_range(0, 7)));
            end
            wb_stall = ($urandom_range(0, 3) == 0);
            rs_addr  = 5'($urandom_range(0, 7));
            rt_addr  = 5'($urandom_range(0, 7));
            rdy = !m_pv || !wb_stall;
            push("rnd_rs", m_read(rs_addr));
            push("rnd_rt", m_read(rt_addr));
            push("rnd_ready", 32'(rdy));
            push("rnd_flags", 32'(m_flags));
            #1;
            e = sb.pop_front(); n_total++;
            if (rs_data !== e.val) $display("FAIL %s@%0d: got %h exp %h", e.name, n, rs_data, e.val);
            else n_pass++;
            e = sb.pop_front(); n_total++;
            if (rt_data !== e.val) $display("FAIL %s@%0d: got %h exp %h", e.name, n, rt_data, e.val);
            else n_pass++;
            e = sb.pop_front(); n_total++;
            if (32'(ex_ready) !== e.val) $display("FAIL %s@%0d: got %h exp %h", e.name, n, ex_ready, e.val);
            else n_pass++;
            e = sb.pop_front(); n_total++;
            if (32'(flags_q) !== e.val) $display("FAIL %s@%0d: got %h exp %h", e.name, n, flags_q, e.val);
            else n_pass++;
            // model the edge
            if (m_pv && !wb_stall) begin
                if (m_pwen && m_pdest != 5'd0) m_regs[m_pdest] = m_pdata;
                if (m_pfen) m_flags = m_pflags;
                m_pv = 1'b0;
            end
            if (ex_valid && rdy) begin
                m_pv = 1'b1; m_pwen = ex_wen; m_pfen = ex_fen;
                m_pdest = ex_dest; m_pdata = ex_result; m_pflags = ex_flags;
            end
            held = ex_valid && !rdy;
            step();
        end
        drive_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 3'd0);
        wb_stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_forward_commit();
        test_back_to_back();
        test_stall();
        test_reg0();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
